// File: rtl/lii_router_pkg.sv
// Shared router definitions: default sizing and output-port FSM encodings.
package lii_router_pkg;

  localparam int LII_N  = 4;
  localparam int LII_DW = 32;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lii_state_e;

endpackage

// File: rtl/lii_output_port_if.sv
// Output-port link bundle: per-input flit streams, arbiter handshake and the output link.
interface lii_output_port_if
  import lii_router_pkg::*;
#(
  parameter int N  = LII_N,
  parameter int DW = LII_DW
) ();

  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_ready;
  logic [N-1:0]    arb_req;
  logic [N-1:0]    arb_gnt;
  logic            arb_gnt_v;
  logic            arb_accept;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            out_ready;

  // port side
  modport master (
    input  in_valid, in_data, in_last, arb_gnt, arb_gnt_v, out_ready,
    output in_ready, arb_req, arb_accept, out_valid, out_data, out_last
  );

  // upstream sources, arbiter and downstream sink
  modport slave (
    output in_valid, in_data, in_last, arb_gnt, arb_gnt_v, out_ready,
    input  in_ready, arb_req, arb_accept, out_valid, out_data, out_last
  );

endinterface

// File: rtl/lii_skid_buffer.sv
// Two-entry valid/ready buffer with registered outputs; in_ready never depends
// combinationally on out_ready.
module lii_skid_buffer
  import lii_router_pkg::*;
#(
  parameter int W = LII_DW + 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic [1:0]   count;
  logic [1:0]   count_nxt;
  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic         push;
  logic         pop;

  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign out_data = head_q;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  // head_q is always the oldest entry; tail_q only holds data while two are stored
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count     <= 2'd0;
      head_q    <= '0;
      tail_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      count     <= count_nxt;
      out_valid <= (count_nxt != 2'd0);
      in_ready  <= (count_nxt != 2'd2);
      if (push) begin
        if (count == 2'd0 || (count == 2'd1 && pop)) head_q <= in_data;
        else                                         tail_q <= in_data;
      end else if (pop && count == 2'd2) begin
        head_q <= tail_q;
      end
    end
  end

endmodule

// File: rtl/lii_output_port.sv
// Router output stage: wormhole lock onto the granted input, one-hot data mux,
// and a two-entry skid buffer toward the output link.
//   state     | meaning
//   ST_IDLE   | forward in_valid as requests, latch the grant into owner
//   ST_LOCKED | stream owner's flits until its last flit transfers
module lii_output_port
  import lii_router_pkg::*;
#(
  parameter int N  = LII_N,
  parameter int DW = LII_DW
) (
  input logic               clk,
  input logic               rstn,
  lii_output_port_if.master bus
);

  lii_state_e    state;
  logic [N-1:0]  owner;
  logic [DW-1:0] sel_data;
  logic          sel_last;
  logic          fire;
  logic          buf_in_ready;
  logic          buf_out_valid;
  logic [DW:0]   buf_out_data;

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      sel_data = sel_data | (bus.in_data[i*DW +: DW] & {DW{owner[i]}});
      sel_last = sel_last | (bus.in_last[i] & owner[i]);
    end
  end

  // holding arb_req at owner keeps the arbiter's grant stable for the whole packet
  assign bus.arb_req    = (state == ST_LOCKED) ? owner : bus.in_valid;
  assign bus.in_ready   = (state == ST_LOCKED) ? (owner & {N{buf_in_ready}}) : '0;
  assign fire           = |(bus.in_valid & bus.in_ready);
  assign bus.arb_accept = fire & sel_last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      owner <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.arb_gnt_v) begin
            owner <= bus.arb_gnt;
            state <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (bus.arb_accept) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  lii_skid_buffer #(.W(DW + 1)) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (fire),
    .in_data   ({sel_last, sel_data}),
    .in_ready  (buf_in_ready),
    .out_valid (buf_out_valid),
    .out_data  (buf_out_data),
    .out_ready (bus.out_ready)
  );

  assign bus.out_valid = buf_out_valid;
  assign bus.out_data  = buf_out_data[DW-1:0];
  assign bus.out_last  = buf_out_data[DW];

endmodule
